// File: rtl/reg_file_mp.sv
// Multi-port register file for the multi-cycle MIPS datapath. It has a hardwired zero register,
// same-cycle write-to-read bypass and a per-register pending scoreboard.
module reg_file_mp #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned ADDRESS_SIZE = 5,
  parameter int unsigned NUM_READ     = 2,
  parameter int unsigned NUM_WRITE    = 1,
  parameter int unsigned ZERO_REG     = 1,
  parameter int unsigned BYPASS       = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_READ*ADDRESS_SIZE-1:0]  ReadReg,
  output logic [NUM_READ*WORD_SIZE-1:0]     ReadData,
  output logic [NUM_READ-1:0]               ReadPending,
  input  logic [NUM_WRITE-1:0]              RegWrite,
  input  logic [NUM_WRITE*ADDRESS_SIZE-1:0] WriteReg,
  input  logic [NUM_WRITE*WORD_SIZE-1:0]    WriteData,
  input  logic                              Reserve,
  input  logic [ADDRESS_SIZE-1:0]           ReserveReg,
  output logic                              AnyPending
);

  localparam int unsigned Depth = 2 ** ADDRESS_SIZE;

  logic [WORD_SIZE-1:0]    mem_q [Depth];
  logic [WORD_SIZE-1:0]    mem_d [Depth];
  logic [Depth-1:0]        pending_q, pending_d;

  logic [ADDRESS_SIZE-1:0] wr_addr [NUM_WRITE];
  logic [WORD_SIZE-1:0]    wr_data [NUM_WRITE];
  logic [NUM_WRITE-1:0]    wr_en;

  function automatic logic is_zero(input logic [ADDRESS_SIZE-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Writes to the zero register are dropped here, so they neither store nor bypass.
  for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wr
    assign wr_addr[k] = WriteReg[k*ADDRESS_SIZE +: ADDRESS_SIZE];
    assign wr_data[k] = WriteData[k*WORD_SIZE +: WORD_SIZE];
    assign wr_en[k]   = RegWrite[k] && !is_zero(wr_addr[k]);
  end

  // Later ports overwrite earlier ones. The reserve is applied last, so it beats a retiring write.
  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (wr_en[k]) begin
        mem_d[wr_addr[k]]     = wr_data[k];
        pending_d[wr_addr[k]] = 1'b0;
      end
    end
    if (Reserve && !is_zero(ReserveReg)) begin
      pending_d[ReserveReg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < Depth; r++) begin
        mem_q[r] <= '0;
      end
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDRESS_SIZE-1:0] rd_addr;
    logic [WORD_SIZE-1:0]    rd_data;
    logic                    rd_pend;

    assign rd_addr = ReadReg[i*ADDRESS_SIZE +: ADDRESS_SIZE];

    always_comb begin
      rd_data = mem_q[rd_addr];
      rd_pend = pending_q[rd_addr];
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WRITE; k++) begin
          if (wr_en[k] && (wr_addr[k] == rd_addr)) begin
            rd_data = wr_data[k];
            rd_pend = 1'b0;
          end
        end
      end
      if (is_zero(rd_addr)) begin
        rd_data = '0;
        rd_pend = 1'b0;
      end
    end

    assign ReadData[i*WORD_SIZE +: WORD_SIZE] = rd_data;
    assign ReadPending[i]                     = rd_pend;
  end

  assign AnyPending = |pending_q;

endmodule
